// File: rtl/video_pll_lock_sequencer_pkg.sv
// rtl/video_pll_lock_sequencer_pkg.sv - shared types and constants for the video PLL lock sequencer
package video_pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } seq_state_e;

    localparam logic [7:0] LOCK_LOST_MAX = 8'd255;
    localparam int         RETRY_W       = 4;

endpackage

// File: rtl/video_pll_lock_sequencer_if.sv
// rtl/video_pll_lock_sequencer_if.sv - PLL handshake and CSR status bundle for the lock sequencer
interface video_pll_lock_sequencer_if;
    import video_pll_seq_pkg::*;

    logic               pll_locked_i;
    logic               relock_req_i;
    logic               pll_rst_o;
    logic               video_rst_o;
    logic               lock_ok_o;
    logic               fail_o;
    logic [RETRY_W-1:0] retry_cnt_o;
    logic [7:0]         lock_lost_cnt_o;

    modport master (
        input  pll_locked_i, relock_req_i,
        output pll_rst_o, video_rst_o, lock_ok_o, fail_o, retry_cnt_o, lock_lost_cnt_o
    );

    modport slave (
        output pll_locked_i, relock_req_i,
        input  pll_rst_o, video_rst_o, lock_ok_o, fail_o, retry_cnt_o, lock_lost_cnt_o
    );

endinterface

// File: rtl/video_pll_lock_sequencer_bit_sync_2ff.sv
// rtl/video_pll_lock_sequencer_bit_sync_2ff.sv - generic two-flop synchronizer, sync active-high reset
module bit_sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/video_pll_lock_sequencer.sv
// rtl/video_pll_lock_sequencer.sv - PLL reset/lock sequencer; PLL_SEQ_LOSS_COUNTER_EN enables lock_lost_cnt
module video_pll_lock_sequencer
    import video_pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 4,
    parameter int CNT_W               = 16
) (
    input  logic refclk_i,
    input  logic rst_i,
    video_pll_lock_sequencer_if.master bus
);

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, video_rst_q, lock_ok_q, fail_q;
    logic               locked_s;

    bit_sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk_i (refclk_i),
        .rst_i (rst_i),
        .d_i   (bus.pll_locked_i),
        .q_o   (locked_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = (retry_d == RETRY_LIMIT) ? FAIL : RESET_PLL;
                end
            end
            STABLE: begin
                // A dropout restarts the lock wait but is not a failed attempt
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                if (!locked_s) state_d = RESET_PLL;
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = RESET_PLL;
            end
        endcase

        if (bus.relock_req_i) begin
            state_d = RESET_PLL;
            retry_d = '0;
        end

        // relock in RESET_PLL keeps the state but must still restart the pulse
        cnt_d = (state_d != state_q || bus.relock_req_i) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            video_rst_q <= 1'b1;
            lock_ok_q   <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= (state_d == RESET_PLL);
            video_rst_q <= (state_d != RUN);
            lock_ok_q   <= (state_d == RUN);
            fail_q      <= (state_d == FAIL);
        end
    end

`ifdef PLL_SEQ_LOSS_COUNTER_EN
    logic [7:0] lost_q, lost_d;

    always_comb begin
        lost_d = lost_q;
        if (!bus.relock_req_i && state_q == RUN && !locked_s && lost_q != LOCK_LOST_MAX)
            lost_d = lost_q + 8'd1;
    end

    always_ff @(posedge refclk_i) begin
        if (rst_i) lost_q <= '0;
        else       lost_q <= lost_d;
    end

    assign bus.lock_lost_cnt_o = lost_q;
`else
    assign bus.lock_lost_cnt_o = 8'd0;
`endif

    assign bus.pll_rst_o   = pll_rst_q;
    assign bus.video_rst_o = video_rst_q;
    assign bus.lock_ok_o   = lock_ok_q;
    assign bus.fail_o      = fail_q;
    assign bus.retry_cnt_o = retry_q;

endmodule

// File: tb/tb_video_pll_lock_sequencer.sv
// tb/tb_video_pll_lock_sequencer.sv - directed bench for the video PLL lock sequencer
module tb_video_pll_lock_sequencer;

    logic refclk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n;

`ifdef PLL_SEQ_LOSS_COUNTER_EN
    localparam int LOST_EN = 1;
`else
    localparam int LOST_EN = 0;
`endif

    video_pll_lock_sequencer_if bus ();

    video_pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (20),
        .MAX_RETRIES         (2),
        .CNT_W               (16)
    ) dut (
        .refclk_i (refclk),
        .rst_i    (rst),
        .bus      (bus)
    );

    always #10 refclk = ~refclk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge
    task automatic step(input int cycles);
        repeat (cycles) @(negedge refclk);
    endtask

    task automatic pulse_relock();
        bus.relock_req_i = 1'b1;
        step(1);
        bus.relock_req_i = 1'b0;
    endtask

    task automatic run_len_pll_rst(input logic lvl, output int len);
        len = 0;
        while (bus.pll_rst_o === lvl && len < 200) begin
            len++;
            step(1);
        end
    endtask

    task automatic wait_lock_ok(input logic lvl);
        int k = 0;
        while (bus.lock_ok_o !== lvl && k < 100) begin
            k++;
            step(1);
        end
        if (k >= 100) check("wait_lock_ok_timeout", k, 0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.pll_locked_i = 1'b0;
        bus.relock_req_i = 1'b0;
        step(3);

        // Reset values, then first lock
        check("rst_pll_rst",   bus.pll_rst_o,       1);
        check("rst_video_rst", bus.video_rst_o,     1);
        check("rst_lock_ok",   bus.lock_ok_o,       0);
        check("rst_fail",      bus.fail_o,          0);
        check("rst_retry",     bus.retry_cnt_o,     0);
        check("rst_lost",      bus.lock_lost_cnt_o, 0);
        rst = 1'b0;
        run_len_pll_rst(1'b1, n);
        check("t1_pulse_len", n, 4);
        step(5);
        bus.pll_locked_i = 1'b1;
        step(10);
        check("t1_not_yet_run", bus.lock_ok_o, 0);
        step(1);
        check("t1_lock_ok",    bus.lock_ok_o,   1);
        check("t1_video_rst",  bus.video_rst_o, 0);
        check("t1_retry",      bus.retry_cnt_o, 0);
        check("t1_pll_rst",    bus.pll_rst_o,   0);

        // Lock loss in RUN, then saturation of the loss counter
        bus.pll_locked_i = 1'b0;
        step(2);
        check("t4_video_rst_e2", bus.video_rst_o, 0);
        step(1);
        check("t4_video_rst_e3", bus.video_rst_o, 1);
        check("t4_pll_rst",      bus.pll_rst_o,   1);
        check("t4_lock_ok",      bus.lock_ok_o,   0);
        check("t4_lost_1",       bus.lock_lost_cnt_o, LOST_EN);
        for (int i = 2; i <= 300; i++) begin
            bus.pll_locked_i = 1'b1;
            wait_lock_ok(1'b1);
            bus.pll_locked_i = 1'b0;
            wait_lock_ok(1'b0);
            if (i == 254) check("t4_lost_254", bus.lock_lost_cnt_o, 254 * LOST_EN);
            if (i == 255) check("t4_lost_255", bus.lock_lost_cnt_o, 255 * LOST_EN);
        end
        check("t4_lost_sat", bus.lock_lost_cnt_o, 255 * LOST_EN);

        // One-cycle dropout at stable count 5
        run_len_pll_rst(1'b1, n);
        check("t3_pulse_len", n, 4);
        bus.pll_locked_i = 1'b1;
        step(6);
        bus.pll_locked_i = 1'b0;
        step(1);
        bus.pll_locked_i = 1'b1;
        step(4);
        check("t3_glitch_no_run", bus.lock_ok_o,   0);
        check("t3_glitch_vrst",   bus.video_rst_o, 1);
        step(6);
        check("t3_full_wait", bus.lock_ok_o, 0);
        step(1);
        check("t3_run",   bus.lock_ok_o,   1);
        check("t3_retry", bus.retry_cnt_o, 0);

        // No lock: relock restart in RESET_PLL, two attempts, then FAIL
        bus.pll_locked_i = 1'b0;
        pulse_relock();
        step(1);
        pulse_relock();
        run_len_pll_rst(1'b1, n);
        check("t2_restart_pulse", n, 4);
        run_len_pll_rst(1'b0, n);
        check("t2_gap", n, 20);
        check("t2_retry_1", bus.retry_cnt_o, 1);
        run_len_pll_rst(1'b1, n);
        check("t2_pulse2", n, 4);
        n = 0;
        while (bus.fail_o !== 1'b1 && n < 200) begin
            n++;
            step(1);
        end
        check("t2_fail_delay", n, 20);
        check("t2_retry_2",  bus.retry_cnt_o, 2);
        check("t2_pll_rst",  bus.pll_rst_o,   0);
        check("t2_vrst",     bus.video_rst_o, 1);
        check("t2_lock_ok",  bus.lock_ok_o,   0);
        step(30);
        check("t2_fail_hold",    bus.fail_o,    1);
        check("t2_pll_rst_hold", bus.pll_rst_o, 0);

        // Escape FAIL via relock_req
        bus.pll_locked_i = 1'b1;
        step(3);
        check("t5_fail_sticky", bus.fail_o, 1);
        pulse_relock();
        check("t5_pll_rst", bus.pll_rst_o,   1);
        check("t5_fail",    bus.fail_o,      0);
        check("t5_retry",   bus.retry_cnt_o, 0);
        step(12);
        check("t5_not_yet_run", bus.lock_ok_o, 0);
        step(1);
        check("t5_run",  bus.lock_ok_o,       1);
        check("t5_lost", bus.lock_lost_cnt_o, 255 * LOST_EN);

        // rst together with relock_req while in STABLE
        pulse_relock();
        step(7);
        check("t6_in_stable", bus.pll_rst_o,   0);
        check("t6_no_run",    bus.lock_ok_o,   0);
        rst              = 1'b1;
        bus.relock_req_i = 1'b1;
        step(1);
        check("t6_pll_rst", bus.pll_rst_o,       1);
        check("t6_vrst",    bus.video_rst_o,     1);
        check("t6_lock_ok", bus.lock_ok_o,       0);
        check("t6_fail",    bus.fail_o,          0);
        check("t6_retry",   bus.retry_cnt_o,     0);
        check("t6_lost",    bus.lock_lost_cnt_o, 0);
        rst              = 1'b0;
        bus.relock_req_i = 1'b0;
        run_len_pll_rst(1'b1, n);
        check("t6_pulse_len", n, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/video_pll_lock_sequencer.md
Name: video_pll_lock_sequencer

Overview:
Sequences reset and lock acquisition for the video PLL, which runs on a 50 MHz reference and produces 25/25/33 MHz outputs. It pulses the PLL reset, waits for a stable lock, and only then releases the synchronous reset for the video clock domains. It detects loss of lock, retries a bounded number of times, and reports status to the Nios II CSR block. It runs on the PLL reference clock, so it keeps operating while the PLL is unlocked.

Parameters:
RST_PULSE_CYCLES, 16, pll_rst high time per attempt, in refclk cycles (must be >=1)
LOCK_STABLE_CYCLES, 1024, consecutive synced-locked cycles required before declaring lock
LOCK_TIMEOUT_CYCLES, 50000, max cycles in WAIT_LOCK before the attempt fails (1 ms at 50 MHz)
MAX_RETRIES, 4, failed attempts allowed before entering FAIL (1..15)
CNT_W, 16, width of the shared cycle counter (must hold the largest of the three cycle parameters)

Ports:
refclk  in  1  50 MHz reference clock; the only clock in the block
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL locked output; asynchronous to refclk
relock_req  in  1  single-cycle software request to re-run the full sequence
pll_rst  out  1  reset to the PLL rst input
video_rst  out  1  active-high reset for downstream video logic
lock_ok  out  1  high only in RUN
fail  out  1  high in FAIL (retries exhausted)
retry_cnt  out  4  failed attempts since the last successful lock or relock_req
lock_lost_cnt  out  8  saturating count of lock-loss events in RUN

Behaviour:
- pll_locked passes through a 2-flop synchronizer, producing locked_s. All decisions use locked_s, which lags pll_locked by 2 cycles.
- Reset values while rst is high: state=RESET_PLL, counter=0, pll_rst=1, video_rst=1, lock_ok=0, fail=0, retry_cnt=0, lock_lost_cnt=0, synchronizer flops=0.
- One CNT_W counter serves all states. It clears on every state change.
- Outputs are registered and decoded from state:
  - pll_rst=1 only in RESET_PLL.
  - video_rst=0 only in RUN.
  - lock_ok=1 only in RUN.
  - fail=1 only in FAIL.
- RESET_PLL: count up to RST_PULSE_CYCLES-1, then go to WAIT_LOCK. pll_rst is therefore high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK:
  - locked_s=1 -> STABLE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT_CYCLES-1: retry_cnt++. If the new retry_cnt equals MAX_RETRIES -> FAIL, else -> RESET_PLL.
- STABLE:
  - locked_s=0 -> WAIT_LOCK. The counter clears, the timeout restarts, and retry_cnt is unchanged.
  - Counter reaches LOCK_STABLE_CYCLES-1 with locked_s still 1 -> RUN, and retry_cnt clears to 0.
- RUN:
  - locked_s=0 -> RESET_PLL. lock_lost_cnt increments and saturates at 255. video_rst asserts the cycle after locked_s falls.
- FAIL: terminal state. Exit only via rst or relock_req.
- relock_req is honoured in any state. Next cycle: state=RESET_PLL, counter=0, retry_cnt=0. lock_lost_cnt is not changed.
- Priority on the same cycle: rst > relock_req > any state transition.
- Glitches on locked_s shorter than LOCK_STABLE_CYCLES during STABLE never reach RUN.
- relock_req arriving while already in RESET_PLL restarts the pulse from count 0.

Optional Feature:
- PLL_SEQ_LOSS_COUNTER_EN defined: lock_lost_cnt is implemented as described above.
- Undefined: lock_lost_cnt is tied to 8'd0 and its register is removed. All other behaviour is identical.

Decomposition:
- Package video_pll_seq_pkg holds:
  - the state enum (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL), 3-bit encoding;
  - the LOCK_LOST_MAX=255 constant;
  - the retry_cnt width constant (4).
- Sub-module: bit_sync_2ff, a generic 2-flop synchronizer with a synchronous active-high reset, instantiated once for pll_locked.

Test Plan:
All scenarios use RST_PULSE=4, STABLE=8, TIMEOUT=20, MAX_RETRIES=2.
1. Release rst and raise pll_locked 5 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; lock_ok=1 and video_rst=0 at 2+8 cycles after the locked edge (±1); retry_cnt=0.
2. Hold pll_locked=0 forever -> two 4-cycle pll_rst pulses 20 cycles apart; then fail=1, retry_cnt=2, pll_rst=0, video_rst=1 held.
3. In STABLE, drop pll_locked for 1 cycle at stable count 5 -> no RUN; return to WAIT_LOCK; full 8 cycles then required; retry_cnt unchanged.
4. In RUN, drop pll_locked -> video_rst=1 within 3 cycles of the drop; pll_rst pulse follows; lock_lost_cnt=1; repeat 300 times -> lock_lost_cnt saturates at 255.
5. In FAIL, pulse relock_req with pll_locked=1 -> RESET_PLL next cycle; fail=0; retry_cnt=0; reaches RUN.
6. Assert rst mid-STABLE together with relock_req -> all reset values next cycle, including lock_lost_cnt=0.
